// File: rtl/issue_queue.sv
// issue_queue - two-wide enqueue, tag wakeup, oldest-first single issue.
// Entries are kept compacted in age order (index 0 oldest), so age survives any amount of churn.
module issue_queue #(
  parameter int IQ_DEPTH  = 16,
  parameter int NUM_WB    = 2,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [1:0]                    in_valid,
  input  logic [1:0]                    in_uses_rs1,
  input  logic [2*TAG_W-1:0]            in_rs1_tag,
  input  logic [1:0]                    in_rs1_ready,
  input  logic [1:0]                    in_uses_rs2,
  input  logic [2*TAG_W-1:0]            in_rs2_tag,
  input  logic [1:0]                    in_rs2_ready,
  input  logic [1:0]                    in_uses_rd,
  input  logic [2*TAG_W-1:0]            in_rd_tag,
  input  logic [2*PAYLOAD_W-1:0]        in_payload,
  output logic                          in_stall,
  input  logic [NUM_WB-1:0]             wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]       wb_tag,
  output logic                          iss_valid,
  input  logic                          iss_ready,
  output logic [TAG_W-1:0]              iss_rs1_tag,
  output logic [TAG_W-1:0]              iss_rs2_tag,
  output logic [TAG_W-1:0]              iss_rd_tag,
  output logic                          iss_uses_rd,
  output logic [PAYLOAD_W-1:0]          iss_payload,
  output logic [$clog2(IQ_DEPTH):0]     count
);

  localparam int CNT_W = $clog2(IQ_DEPTH) + 1;
  localparam int IDX_W = $clog2(IQ_DEPTH);

  typedef struct packed {
    logic                 valid;
    logic                 r1;
    logic                 r2;
    logic                 uses_rd;
    logic [TAG_W-1:0]     rs1_tag;
    logic [TAG_W-1:0]     rs2_tag;
    logic [TAG_W-1:0]     rd_tag;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t           ent_q [IQ_DEPTH];
  entry_t           ent_d [IQ_DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  entry_t              woken [IQ_DEPTH+1];
  entry_t              new_ent [2];
  logic [IQ_DEPTH-1:0] eligible;
  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic                block, deq, enq0, enq1;
  logic [CNT_W-1:0]    base, pos0, pos1;

  function automatic logic tag_hit(input logic [TAG_W-1:0] tag,
                                   input logic [NUM_WB-1:0] v,
                                   input logic [NUM_WB*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (v[k] && (tags[k*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    block     = reset | flush;
    sel_found = 1'b0;
    sel_idx   = '0;
    woken[IQ_DEPTH] = '0;
    for (int j = 0; j < IQ_DEPTH; j++) begin
      // Eligibility uses stored ready bits, so a wakeup only counts from the next cycle.
      eligible[j] = ent_q[j].valid & ent_q[j].r1 & ent_q[j].r2;
      woken[j]    = ent_q[j];
      woken[j].r1 = ent_q[j].r1 | tag_hit(ent_q[j].rs1_tag, wb_valid, wb_tag);
      woken[j].r2 = ent_q[j].r2 | tag_hit(ent_q[j].rs2_tag, wb_valid, wb_tag);
      if (eligible[j] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(j);
      end
    end

    iss_valid   = sel_found & ~block;
    iss_rs1_tag = ent_q[sel_idx].rs1_tag;
    iss_rs2_tag = ent_q[sel_idx].rs2_tag;
    iss_rd_tag  = ent_q[sel_idx].rd_tag;
    iss_uses_rd = ent_q[sel_idx].uses_rd;
    iss_payload = ent_q[sel_idx].payload;
    deq         = iss_valid & iss_ready;

    in_stall = ~block & (count_q > CNT_W'(IQ_DEPTH - 2));
    enq0     = in_valid[0] & ~in_stall & ~block;
    enq1     = in_valid[1] & ~in_stall & ~block;
    base     = count_q - CNT_W'(deq);
    pos0     = base;
    pos1     = base + CNT_W'(enq0);

    for (int i = 0; i < 2; i++) begin
      new_ent[i].valid   = 1'b1;
      new_ent[i].r1      = ~in_uses_rs1[i] | in_rs1_ready[i]
                           | tag_hit(in_rs1_tag[i*TAG_W +: TAG_W], wb_valid, wb_tag);
      new_ent[i].r2      = ~in_uses_rs2[i] | in_rs2_ready[i]
                           | tag_hit(in_rs2_tag[i*TAG_W +: TAG_W], wb_valid, wb_tag);
      new_ent[i].uses_rd = in_uses_rd[i];
      new_ent[i].rs1_tag = in_rs1_tag[i*TAG_W +: TAG_W];
      new_ent[i].rs2_tag = in_rs2_tag[i*TAG_W +: TAG_W];
      new_ent[i].rd_tag  = in_rd_tag[i*TAG_W +: TAG_W];
      new_ent[i].payload = in_payload[i*PAYLOAD_W +: PAYLOAD_W];
    end

    // Collapse over the issued slot, then append new slots after the survivors.
    for (int j = 0; j < IQ_DEPTH; j++) begin
      ent_d[j] = (deq && (IDX_W'(j) >= sel_idx)) ? woken[j+1] : woken[j];
      if (enq0 && (CNT_W'(j) == pos0)) ent_d[j] = new_ent[0];
      if (enq1 && (CNT_W'(j) == pos1)) ent_d[j] = new_ent[1];
      if (block) ent_d[j] = '0;
    end

    count_d = block ? '0 : count_q - CNT_W'(deq) + CNT_W'(enq0) + CNT_W'(enq1);
    count   = count_q;
  end

  always_ff @(posedge clk) begin
    ent_q   <= ent_d;
    count_q <= count_d;
  end

endmodule
